// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: FSM encoding, control-field layout,
// flag ordering and logic-function indices used by the external ALU.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // 6-bit per-requester control word: {invert_a, invert_b, is_logic, func[2:0]}
    localparam int CTL_W        = 6;
    localparam int CTL_FUNC_LSB = 0;
    localparam int CTL_FUNC_MSB = 2;
    localparam int CTL_IS_LOGIC = 3;
    localparam int CTL_INVERT_B = 4;
    localparam int CTL_INVERT_A = 5;

    // NZCV register bit order
    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    // Logic function indices understood by the ALU when is_logic is set
    localparam logic [2:0] FUNC_AND    = 3'd0;
    localparam logic [2:0] FUNC_OR     = 3'd1;
    localparam logic [2:0] FUNC_XOR    = 3'd2;
    localparam logic [2:0] FUNC_PASS_B = 3'd3;

    // Extract the 32-bit operand of requester idx from a packed 64-bit bus
    function automatic logic [31:0] word_field(input logic [63:0] w, input logic idx);
        return idx ? w[63:32] : w[31:0];
    endfunction

    // Extract the control word of requester idx from the packed 12-bit bus
    function automatic logic [CTL_W-1:0] ctl_field(input logic [2*CTL_W-1:0] c, input logic idx);
        return idx ? c[2*CTL_W-1:CTL_W] : c[CTL_W-1:0];
    endfunction

    // Assemble ALU flag outputs into NZCV order
    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter: two requesters sharing one response port.
interface alu_arbiter_if;
    import alu_pkg::*;

    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [63:0]        req_a;
    logic [63:0]        req_b;
    logic [2*CTL_W-1:0] req_ctl;
    logic [1:0]         req_cin;
    logic [1:0]         req_setflags;
    logic [1:0]         rsp_valid;
    logic [31:0]        rsp_result;
    logic [3:0]         rsp_flags;

    modport master (
        output req_valid, req_a, req_b, req_ctl, req_cin, req_setflags,
        input  req_ready, rsp_valid, rsp_result, rsp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ctl, req_cin, req_setflags,
        output req_ready, rsp_valid, rsp_result, rsp_flags
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a tie
// and flips to the other requester after every accepted grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic       ptr_r;
    logic [1:0] grant_s;

    // Grant selection: lone requester wins, tie resolved by the pointer
    always_comb begin
        grant_s = 2'b00;
        case (req)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = ptr_r ? 2'b10 : 2'b01;
            default: grant_s = 2'b00;
        endcase
    end

    // Priority pointer: hand priority to the requester that was not served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 1'b0;
        end else if (advance && (grant_s != 2'b00)) begin
            ptr_r <= grant_s[0];
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared external ALU. An accepted operation
// is latched, presented to the ALU for EXEC_CYCLES cycles (legal 1..15), then the
// result is captured and returned as a one-cycle response pulse.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int EXEC_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_arbiter_if.slave bus,
    output logic [3:0]  nzcv,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_invert_a,
    output logic        alu_invert_b,
    output logic        alu_is_logic,
    output logic        alu_cin,
    output logic        alu_active,
    output logic [2:0]  alu_func,
    input  logic [31:0] alu_result,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_c,
    input  logic        alu_v
);

    localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [1:0]         grant_s;
    logic [1:0]         ready_s;
    logic               advance_s;
    logic               gidx_s;
    logic               last_s;
    logic [3:0]         cnt_r;
    logic               idx_r;
    logic               cin_r;
    logic               setflags_r;
    logic               active_r;
    logic [31:0]        a_r;
    logic [31:0]        b_r;
    logic [CTL_W-1:0]   ctl_r;
    logic [1:0]         rsp_valid_r;
    logic [31:0]        rsp_result_r;
    logic [3:0]         rsp_flags_r;
    logic [3:0]         nzcv_r;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req_valid),
        .advance (advance_s),
        .grant   (grant_s)
    );

    // Handshake: accept only in IDLE and never while reset is asserted
    always_comb begin
        ready_s = 2'b00;
        if (rst_n && (state_r == ST_IDLE)) begin
            ready_s = grant_s & bus.req_valid;
        end else begin
            ready_s = 2'b00;
        end
    end

    assign advance_s = |ready_s;
    assign gidx_s    = ready_s[1];
    assign last_s    = (state_r == ST_EXEC) && (cnt_r == LAST_CNT);

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (advance_s) state_nxt_s = ST_EXEC;
                else           state_nxt_s = ST_IDLE;
            end
            ST_EXEC: begin
                if (last_s) state_nxt_s = ST_DONE;
                else        state_nxt_s = ST_EXEC;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_nxt_s;
    end

    // ALU-active flag, registered so it is high exactly during EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) active_r <= 1'b0;
        else        active_r <= (state_nxt_s == ST_EXEC);
    end

    // Operand latch: captures the granted request; held until the next grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r        <= 32'd0;
            b_r        <= 32'd0;
            ctl_r      <= {CTL_W{1'b0}};
            cin_r      <= 1'b0;
            setflags_r <= 1'b0;
            idx_r      <= 1'b0;
        end else if (advance_s) begin
            a_r        <= word_field(bus.req_a, gidx_s);
            b_r        <= word_field(bus.req_b, gidx_s);
            ctl_r      <= ctl_field(bus.req_ctl, gidx_s);
            cin_r      <= bus.req_cin[gidx_s];
            setflags_r <= bus.req_setflags[gidx_s];
            idx_r      <= gidx_s;
        end else begin
            a_r        <= a_r;
            b_r        <= b_r;
            ctl_r      <= ctl_r;
            cin_r      <= cin_r;
            setflags_r <= setflags_r;
            idx_r      <= idx_r;
        end
    end

    // Execution counter: counts EXEC cycles, restarts on each grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 4'd0;
        end else if (advance_s || last_s) begin
            cnt_r <= 4'd0;
        end else if (state_r == ST_EXEC) begin
            cnt_r <= cnt_r + 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Response capture: sample ALU on the final EXEC cycle, pulse valid in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r  <= 2'b00;
            rsp_result_r <= 32'd0;
            rsp_flags_r  <= 4'd0;
        end else if (last_s) begin
            rsp_valid_r  <= {idx_r, ~idx_r};
            rsp_result_r <= alu_result;
            rsp_flags_r  <= pack_flags(alu_n, alu_z, alu_c, alu_v);
        end else begin
            rsp_valid_r  <= 2'b00;
            rsp_result_r <= rsp_result_r;
            rsp_flags_r  <= rsp_flags_r;
        end
    end

    // Architectural flags: commit at the end of DONE when the op asked for it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzcv_r <= 4'd0;
        end else if ((state_r == ST_DONE) && setflags_r) begin
            nzcv_r <= rsp_flags_r;
        end else begin
            nzcv_r <= nzcv_r;
        end
    end

    assign bus.req_ready  = ready_s;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_result = rsp_result_r;
    assign bus.rsp_flags  = rsp_flags_r;
    assign nzcv           = nzcv_r;
    assign alu_a          = a_r;
    assign alu_b          = b_r;
    assign alu_invert_a   = ctl_r[CTL_INVERT_A];
    assign alu_invert_b   = ctl_r[CTL_INVERT_B];
    assign alu_is_logic   = ctl_r[CTL_IS_LOGIC];
    assign alu_func       = ctl_r[CTL_FUNC_MSB:CTL_FUNC_LSB];
    assign alu_cin        = cin_r;
    assign alu_active     = active_r;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter EXEC_CYCLES, default 2: number of cycles the ALU operands are held stable before the result is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 req_valid  input  2  bit i: requester i presents an operation.
REQ-005 req_ready  output  2  bit i: operation of requester i accepted this cycle.
REQ-006 req_a  input  64  operand A; requester i at bits [32i+31:32i].
REQ-007 req_b  input  64  operand B; same packing as req_a.
REQ-008 req_ctl  input  12  per requester 6 bits at [6i+5:6i]: {invert_a, invert_b, is_logic, func[2:0]}.
REQ-009 req_cin  input  2  carry-in per requester.
REQ-010 req_setflags  input  2  bit i: update NZCV register on completion.
REQ-011 rsp_valid  output  2  bit i: one-cycle pulse, result for requester i is on rsp_result/rsp_flags.
REQ-012 rsp_result  output  32  captured ALU result.
REQ-013 rsp_flags  output  4  captured {N,Z,C,V} of this operation.
REQ-014 nzcv  output  4  architectural flag register {N,Z,C,V}.
REQ-015 alu_a, alu_b  output  32 each  operands to shared ALU.
REQ-016 alu_invert_a, alu_invert_b, alu_is_logic, alu_cin, alu_active  output  1 each  ALU controls.
REQ-017 alu_func  output  3  ALU logic function index.
REQ-018 alu_result  input  32; alu_n, alu_z, alu_c, alu_v  input  1 each  ALU outputs.

Function
REQ-019 FSM states SHALL be IDLE, EXEC, DONE.
REQ-020 IDLE: if any req_valid, grant one requester, assert its req_ready for exactly that cycle, latch its a/b/ctl/cin/setflags and index, go to EXEC; else stay.
REQ-021 req_ready SHALL be combinational: high only in IDLE, only for granted requester, only when its req_valid is high; never both bits.
REQ-022 Arbitration: round-robin; single valid wins; both valid -> requester at priority pointer wins; pointer moves to the other requester after each grant.
REQ-023 EXEC: alu_* driven from latched registers, alu_active=1, 4-bit counter counts EXEC_CYCLES cycles; on final cycle sample alu_result and flags into response registers, go to DONE.
REQ-024 Outside EXEC alu_active=0 and alu_* operand/control outputs hold last latched values.
REQ-025 DONE: rsp_valid pulses one cycle on latched index bit; rsp_result/rsp_flags valid that cycle and held until next DONE; if latched setflags, nzcv takes rsp_flags at end of DONE; go to IDLE.
REQ-026 Latency: handshake at cycle T -> rsp_valid at T+EXEC_CYCLES+1; one op per EXEC_CYCLES+2 cycles max.
REQ-027 req_valid changes on non-granted requester while busy SHALL be ignored; no queueing; requester holds valid until ready.
REQ-028 No response backpressure; requester must accept rsp_valid when issued.
REQ-029 setflags=0 SHALL leave nzcv unchanged.

Reset
REQ-030 rst_n low SHALL force immediately: state IDLE, counter 0, pointer to requester 0, req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0, nzcv=0, all alu_* outputs 0.
REQ-031 Reset during EXEC or DONE SHALL abort the operation: no rsp_valid, no nzcv update after release.

Structure
REQ-032 Shared package alu_pkg SHALL hold state encoding, 6-bit ctl field positions, NZCV bit order, logic function index constants.
REQ-033 Round-robin grant logic SHALL be sub-module rr_arbiter2 (inputs req[1:0], advance; output grant[1:0]); ALU itself instantiated outside this block.

Verification
REQ-034 Single: req0 a=5,b=3,ctl add,cin=0,setflags=1 -> req_ready[0] at T, rsp_valid[0] at T+3, result 8, nzcv=0000.
REQ-035 Contention: both valid from reset -> requester 0 first, requester 1 granted in next IDLE, then 0 again if still valid.
REQ-036 Zero/flags: a=7,b=7 with invert_b,cin=1 (subtract), setflags=1 -> result 0, Z=1, C=1; second op setflags=0 leaves nzcv=0110.
REQ-037 Logic: is_logic AND a=F0F0F0F0,b=FF00FF00 -> result F000F000, rsp_valid on correct bit only.
REQ-038 Reset mid-op: rst_n low during EXEC -> outputs zero immediately, no rsp_valid after release, next request served normally.
REQ-039 EXEC_CYCLES=1 and =15: response latency 2 and 16 cycles respectively; alu_active high exactly EXEC_CYCLES cycles.
